// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard; reads are combinational (0-cycle), writes/marks land on posedge.
// No backpressure: every enabled write and mark is accepted on the edge it is presented.
module regfile_mp #(
    parameter int DW       = 32,
    parameter int NREGS    = 32,
    parameter int AW       = (NREGS > 1) ? $clog2(NREGS) : 1,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk_i,
    input  logic              aclr_n_i,
    input  logic [NRD*AW-1:0] rd_addr_i,
    output logic [NRD*DW-1:0] rd_data_o,
    output logic [NRD-1:0]    rd_busy_o,
    input  logic [NWR-1:0]    wr_en_i,
    input  logic [NWR*AW-1:0] wr_addr_i,
    input  logic [NWR*DW-1:0] wr_data_i,
    input  logic              mark_en_i,
    input  logic [AW-1:0]     mark_addr_i,
    output logic [NREGS-1:0]  busy_vec_o
);

    logic [DW-1:0]    mem_q [NREGS];
    logic [DW-1:0]    mem_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Out-of-range addresses and (optionally) r0 are inert for reads, writes and marks.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        addr_ok = (int'(a) < NREGS) && ((ZERO_REG == 0) || (a != '0));
    endfunction

    logic [NWR-1:0] wr_ok;
    logic           mark_ok;

    always_comb begin
        wr_ok = '0;
        for (int p = 0; p < NWR; p++) begin
            wr_ok[p] = wr_en_i[p] && addr_ok(wr_addr_i[p*AW +: AW]);
        end
        mark_ok = mark_en_i && addr_ok(mark_addr_i);
    end

    // Ascending port order lets the highest-index writer win; the mark is applied last so a new producer wins.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            mem_d[r]  = mem_q[r];
            busy_d[r] = busy_q[r];
            for (int p = 0; p < NWR; p++) begin
                if (wr_ok[p] && (int'(wr_addr_i[p*AW +: AW]) == r)) begin
                    mem_d[r]  = wr_data_i[p*DW +: DW];
                    busy_d[r] = 1'b0;
                end
            end
            if (mark_ok && (int'(mark_addr_i) == r)) begin
                busy_d[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge aclr_n_i) begin
        if (!aclr_n_i) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= mem_d[r];
            end
            busy_q <= busy_d;
        end
    end

    assign busy_vec_o = busy_q;

    logic [AW-1:0] rd_a [NRD];

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_a[i] = rd_addr_i[i*AW +: AW];
            // Reset gating keeps the bypass path from leaking write data while aclr_n is held.
            if (aclr_n_i && addr_ok(rd_a[i])) begin
                rd_data_o[i*DW +: DW] = mem_q[rd_a[i]];
                rd_busy_o[i]          = busy_q[rd_a[i]];
                if (BYPASS != 0) begin
                    for (int p = 0; p < NWR; p++) begin
                        if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] == rd_a[i])) begin
                            rd_data_o[i*DW +: DW] = wr_data_i[p*DW +: DW];
                            rd_busy_o[i]          = 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (32x2R2W bypass, 24x3R1W no bypass) against an array model.
module tb_regfile_mp;

    logic clk;
    logic aclr_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus per instance k: 0 = default config, 1 = NREGS=24/NRD=3/NWR=1/BYPASS=0
    logic [4:0]  rda [2][3];
    logic        wen [2][2];
    logic [4:0]  wa  [2][2];
    logic [31:0] wd  [2][2];
    logic        mk  [2];
    logic [4:0]  ma  [2];

    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic [31:0] a_busy_vec;
    logic [95:0] b_rd_data;
    logic [2:0]  b_rd_busy;
    logic [23:0] b_busy_vec;

    regfile_mp #(.DW(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk_i       (clk),
        .aclr_n_i    (aclr_n),
        .rd_addr_i   ({rda[0][1], rda[0][0]}),
        .rd_data_o   (a_rd_data),
        .rd_busy_o   (a_rd_busy),
        .wr_en_i     ({wen[0][1], wen[0][0]}),
        .wr_addr_i   ({wa[0][1], wa[0][0]}),
        .wr_data_i   ({wd[0][1], wd[0][0]}),
        .mark_en_i   (mk[0]),
        .mark_addr_i (ma[0]),
        .busy_vec_o  (a_busy_vec)
    );

    regfile_mp #(.DW(32), .NREGS(24), .NRD(3), .NWR(1), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk_i       (clk),
        .aclr_n_i    (aclr_n),
        .rd_addr_i   ({rda[1][2], rda[1][1], rda[1][0]}),
        .rd_data_o   (b_rd_data),
        .rd_busy_o   (b_rd_busy),
        .wr_en_i     (wen[1][0]),
        .wr_addr_i   (wa[1][0]),
        .wr_data_i   (wd[1][0]),
        .mark_en_i   (mk[1]),
        .mark_addr_i (ma[1]),
        .busy_vec_o  (b_busy_vec)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mreg  [2][32];
    logic        mbusy [2][32];

    function automatic int p_nregs(int k); return (k == 0) ? 32 : 24; endfunction
    function automatic int p_nrd(int k);   return (k == 0) ? 2 : 3;   endfunction
    function automatic int p_nwr(int k);   return (k == 0) ? 2 : 1;   endfunction
    function automatic bit p_byp(int k);   return (k == 0);           endfunction

    function automatic bit m_ok(int k, int a);
        return (a < p_nregs(k)) && (a != 0);
    endfunction

    function automatic logic [31:0] exp_data(int k, int i);
        int a = int'(rda[k][i]);
        logic [31:0] d;
        if (!aclr_n || !m_ok(k, a)) return 32'h0;
        d = mreg[k][a];
        if (p_byp(k))
            for (int p = 0; p < p_nwr(k); p++)
                if (wen[k][p] && int'(wa[k][p]) == a) d = wd[k][p];
        return d;
    endfunction

    function automatic logic exp_busy(int k, int i);
        int a = int'(rda[k][i]);
        logic b;
        if (!aclr_n || !m_ok(k, a)) return 1'b0;
        b = mbusy[k][a];
        if (p_byp(k))
            for (int p = 0; p < p_nwr(k); p++)
                if (wen[k][p] && int'(wa[k][p]) == a) b = 1'b0;
        return b;
    endfunction

    function automatic logic [31:0] exp_bvec(int k);
        logic [31:0] v = '0;
        for (int r = 0; r < p_nregs(k); r++) v[r] = mbusy[k][r];
        return v;
    endfunction

    function automatic logic [31:0] dut_data(int k, int i);
        if (k == 0) return (i == 0) ? a_rd_data[31:0] : a_rd_data[63:32];
        case (i)
            0:       return b_rd_data[31:0];
            1:       return b_rd_data[63:32];
            default: return b_rd_data[95:64];
        endcase
    endfunction

    function automatic logic dut_busy(int k, int i);
        return (k == 0) ? a_rd_busy[i] : b_rd_busy[i];
    endfunction

    function automatic logic [31:0] dut_bvec(int k);
        return (k == 0) ? a_busy_vec : {8'h0, b_busy_vec};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_clear();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 32; r++) begin
                mreg[k][r]  = '0;
                mbusy[k][r] = 1'b0;
            end
    endtask

    task automatic m_edge();
        if (!aclr_n) return;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < p_nwr(k); p++)
                if (wen[k][p] && m_ok(k, int'(wa[k][p]))) begin
                    mreg[k][wa[k][p]]  = wd[k][p];
                    mbusy[k][wa[k][p]] = 1'b0;
                end
            if (mk[k] && m_ok(k, int'(ma[k]))) mbusy[k][ma[k]] = 1'b1;
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < p_nrd(k); i++) begin
                chk($sformatf("rd_data k%0d p%0d", k, i), dut_data(k, i), exp_data(k, i));
                chk($sformatf("rd_busy k%0d p%0d", k, i), 32'(dut_busy(k, i)), 32'(exp_busy(k, i)));
            end
            chk($sformatf("busy_vec k%0d", k), dut_bvec(k), exp_bvec(k));
        end
    endtask

    // Entered just after a negedge with inputs already driven.
    task automatic cycle();
        #2;
        compare_all();
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) rda[k][i] = '0;
            for (int p = 0; p < 2; p++) begin
                wen[k][p] = 1'b0;
                wa[k][p]  = '0;
                wd[k][p]  = '0;
            end
            mk[k] = 1'b0;
            ma[k] = '0;
        end
    endtask

    task automatic set_rd(int k, logic [4:0] a);
        for (int i = 0; i < 3; i++) rda[k][i] = a;
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        aclr_n = 1'b0;
        idle();
        m_clear();
        @(negedge clk);
        cycle();
        chk("reset busy_vec a", a_busy_vec, 32'h0);
        aclr_n = 1'b1;

        // Write r1, same-cycle visibility only where forwarding exists.
        for (int k = 0; k < 2; k++) begin
            wen[k][0] = 1'b1; wa[k][0] = 5'd1; wd[k][0] = 32'hF0F0F0F0; set_rd(k, 5'd1);
        end
        #2;
        chk("wr1 same cycle bypass", a_rd_data[31:0], 32'hF0F0F0F0);
        chk("wr1 same cycle nobypass", b_rd_data[95:64], 32'h0);
        cycle();
        idle(); set_rd(0, 5'd1); set_rd(1, 5'd1);
        #2;
        chk("wr1 next a port0", a_rd_data[31:0], 32'hF0F0F0F0);
        chk("wr1 next a port1", a_rd_data[63:32], 32'hF0F0F0F0);
        chk("wr1 next b port2", b_rd_data[95:64], 32'hF0F0F0F0);
        cycle();

        // Collision priority on the two-writer instance.
        idle();
        wen[0][0] = 1'b1; wa[0][0] = 5'd5; wd[0][0] = 32'h1111;
        wen[0][1] = 1'b1; wa[0][1] = 5'd5; wd[0][1] = 32'h2222;
        set_rd(0, 5'd5);
        #2;
        chk("collision bypass", a_rd_data[31:0], 32'h2222);
        cycle();
        idle(); set_rd(0, 5'd5);
        #2;
        chk("collision stored", a_rd_data[63:32], 32'h2222);
        cycle();

        // Scoreboard on r7.
        idle();
        for (int k = 0; k < 2; k++) begin mk[k] = 1'b1; ma[k] = 5'd7; set_rd(k, 5'd7); end
        #2;
        chk("mark not yet visible", 32'(a_rd_busy[0]), 32'h0);
        cycle();
        idle(); set_rd(0, 5'd7); set_rd(1, 5'd7);
        #2;
        chk("mark busy a", 32'(a_rd_busy[1]), 32'h1);
        chk("mark busy_vec a", 32'(a_busy_vec[7]), 32'h1);
        chk("mark busy b", 32'(b_rd_busy[2]), 32'h1);
        cycle();
        for (int k = 0; k < 2; k++) begin wen[k][0] = 1'b1; wa[k][0] = 5'd7; wd[k][0] = 32'hABCD; end
        #2;
        chk("wr7 bypass busy", 32'(a_rd_busy[0]), 32'h0);
        chk("wr7 bypass data", a_rd_data[31:0], 32'hABCD);
        chk("wr7 nobypass busy", 32'(b_rd_busy[0]), 32'h1);
        chk("wr7 nobypass data", b_rd_data[31:0], 32'h0);
        cycle();
        idle(); set_rd(0, 5'd7); set_rd(1, 5'd7);
        #2;
        chk("wr7 cleared a", 32'(a_busy_vec[7]), 32'h0);
        chk("wr7 cleared b", 32'(b_busy_vec[7]), 32'h0);
        chk("wr7 stored b", b_rd_data[63:32], 32'hABCD);
        cycle();
        for (int k = 0; k < 2; k++) begin
            mk[k] = 1'b1; ma[k] = 5'd7; wen[k][0] = 1'b1; wa[k][0] = 5'd7; wd[k][0] = 32'h1234;
        end
        cycle();
        idle(); set_rd(0, 5'd7); set_rd(1, 5'd7);
        #2;
        chk("mark+wr busy a", 32'(a_busy_vec[7]), 32'h1);
        chk("mark+wr data a", a_rd_data[31:0], 32'h1234);
        chk("mark+wr data b", b_rd_data[31:0], 32'h1234);
        cycle();

        // r0 immunity.
        idle();
        for (int k = 0; k < 2; k++) begin
            wen[k][0] = 1'b1; wa[k][0] = 5'd0; wd[k][0] = 32'hF0F0F0F0; mk[k] = 1'b1; ma[k] = 5'd0;
        end
        #2;
        chk("r0 bypass data", a_rd_data[31:0], 32'h0);
        chk("r0 bypass busy", 32'(a_rd_busy[0]), 32'h0);
        cycle();
        idle();
        #2;
        chk("r0 busy_vec", 32'(a_busy_vec[0]), 32'h0);
        chk("r0 data after", a_rd_data[31:0], 32'h0);
        cycle();

        // Out-of-range r30 on the 24-entry instance.
        idle();
        wen[1][0] = 1'b1; wa[1][0] = 5'd30; wd[1][0] = 32'hDEADBEEF; mk[1] = 1'b1; ma[1] = 5'd30;
        set_rd(1, 5'd30);
        cycle();
        idle(); set_rd(1, 5'd30);
        #2;
        chk("r30 data b", b_rd_data[31:0], 32'h0);
        chk("r30 busy b", 32'(b_rd_busy[1]), 32'h0);
        chk("r30 busy_vec b", {8'h0, b_busy_vec}, 32'h80);
        cycle();

        // Reset asserted mid-run with writes pending: zero at once, held 3 clocks, writes discarded.
        for (int k = 0; k < 2; k++) begin
            wen[k][0] = 1'b1; wa[k][0] = 5'd1; wd[k][0] = 32'h5A5A5A5A; mk[k] = 1'b1; ma[k] = 5'd3;
            set_rd(k, 5'd1);
        end
        aclr_n = 1'b0;
        m_clear();
        #1;
        chk("reset immediate data", a_rd_data[31:0], 32'h0);
        chk("reset immediate busy_vec", a_busy_vec, 32'h0);
        for (int n = 0; n < 3; n++) cycle();
        aclr_n = 1'b1;
        idle(); set_rd(0, 5'd1); set_rd(1, 5'd1);
        #2;
        chk("post reset r1 a", a_rd_data[31:0], 32'h0);
        chk("post reset busy_vec b", {8'h0, b_busy_vec}, 32'h0);
        cycle();

        // Randomized traffic with occasional asynchronous reset pulses.
        for (int c = 0; c < 2000; c++) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 3; i++) rda[k][i] = rnd_addr();
                for (int p = 0; p < 2; p++) begin
                    wen[k][p] = ($urandom_range(0, 1) == 1);
                    wa[k][p]  = rnd_addr();
                    wd[k][p]  = $urandom;
                end
                mk[k] = ($urandom_range(0, 2) == 0);
                ma[k] = rnd_addr();
            end
            aclr_n = ($urandom_range(0, 99) != 0);
            if (!aclr_n) m_clear();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
